// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit with a multi-cycle register scoreboard for an in-order pipeline.
// Latency: all outputs are combinational from the current inputs and state; state updates land next cycle.
// Backpressure: StallF/StallD hold fetch/decode on a load-use or scoreboard hazard; flushes squash D/E.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   RA1D/RA2D/WA3D, Use*/WriteD decode-stage operands and destination
//   RA1E/RA2E/WA3E, MemtoRegE   execute-stage addresses, load-in-execute flag
//   WA3M/WA3W, RegWriteM/W      memory/writeback destinations for forwarding
//   PCSrcD, BranchTakenE        PC-writing op in decode, branch taken in execute
//   MCIssueE/MCLatE/MCKill      multi-cycle issue, its writeback latency, clear all
//   ForwardAE/BE, Stall*/Flush* forwarding selects and pipeline control
//   SBBusy                      per-register busy vector
module hazard_scoreboard_unit #(
  parameter int AW = 3,
  parameter int LW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     RA1D,
  input  logic [AW-1:0]     RA2D,
  input  logic [AW-1:0]     WA3D,
  input  logic              UseAD,
  input  logic              UseBD,
  input  logic              WriteD,
  input  logic [AW-1:0]     RA1E,
  input  logic [AW-1:0]     RA2E,
  input  logic [AW-1:0]     WA3E,
  input  logic [AW-1:0]     WA3M,
  input  logic [AW-1:0]     WA3W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCSrcD,
  input  logic              BranchTakenE,
  input  logic              MCIssueE,
  input  logic [LW-1:0]     MCLatE,
  input  logic              MCKill,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [(2**AW)-1:0] SBBusy
);

  localparam int NREG = 2 ** AW;

  logic [LW-1:0] cnt_q [NREG];
  logic [LW-1:0] cnt_d [NREG];
  logic [2:0]    pend_q;
  logic [2:0]    pend_d;
  logic          ldr_stall;
  logic          sb_stall;

  // Forwarding: the Memory stage holds the younger result, so it wins ties.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RA1E == WA3M))      ForwardAE = 2'b10;
    else if (RegWriteW && (RA1E == WA3W)) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RegWriteM && (RA2E == WA3M))      ForwardBE = 2'b10;
    else if (RegWriteW && (RA2E == WA3W)) ForwardBE = 2'b01;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      SBBusy[r] = (cnt_q[r] != '0);
    end
  end

  assign ldr_stall = MemtoRegE && ((UseAD && (RA1D == WA3E)) || (UseBD && (RA2D == WA3E)));

  // RAW on either source, WAW on the destination, against in-flight multi-cycle ops.
  assign sb_stall = (UseAD && SBBusy[RA1D]) || (UseBD && SBBusy[RA2D]) || (WriteD && SBBusy[WA3D]);

  assign StallD = ldr_stall || sb_stall;
  assign StallF = StallD || PCSrcD || pend_q[0] || pend_q[1];
  assign FlushE = StallD || BranchTakenE;
  assign FlushD = PCSrcD || (|pend_q) || BranchTakenE;

  // Kill beats issue; a zero-latency issue is ignored; a fresh load beats the decrement.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (MCKill) begin
        cnt_d[r] = '0;
      end else if (MCIssueE && (MCLatE != '0) && (WA3E == AW'(r))) begin
        cnt_d[r] = MCLatE;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - {{(LW-1){1'b0}}, 1'b1};
      end
    end
  end

  // A PC write in decode that is neither stalled nor squashed by a taken branch
  // walks E, M, W; each slot keeps fetch/decode blocked until the PC settles.
  assign pend_d = {pend_q[1], pend_q[0], PCSrcD && !StallD && !BranchTakenE};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      pend_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: per-scenario tasks push
// expected outputs to a queue when inputs are driven and pop/compare them
// at the falling edge, when the combinational outputs have settled.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       UseAD, UseBD, WriteD, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, BranchTakenE, MCIssueE, MCKill;
  logic [3:0] MCLatE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE;
  logic [7:0] SBBusy;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       sf;
    logic       sd;
    logic       fd;
    logic       fe;
    logic [7:0] busy;
  } out_t;

  out_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  hazard_scoreboard_unit #(.AW(3), .LW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .UseAD(UseAD), .UseBD(UseBD), .WriteD(WriteD),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
    .MCIssueE(MCIssueE), .MCLatE(MCLatE), .MCKill(MCKill),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .SBBusy(SBBusy)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [1:0] fa, input logic [1:0] fb,
                              input logic sf, input logic sd, input logic fd,
                              input logic fe, input logic [7:0] busy);
    out_t o;
    o.fa = fa; o.fb = fb; o.sf = sf; o.sd = sd; o.fd = fd; o.fe = fe; o.busy = busy;
    return o;
  endfunction

  function automatic out_t observed();
    return mk(ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, SBBusy);
  endfunction

  task automatic idle_inputs();
    RA1D = 0; RA2D = 0; WA3D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    UseAD = 0; UseBD = 0; WriteD = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcD = 0; BranchTakenE = 0; MCIssueE = 0; MCLatE = 0; MCKill = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    out_t e, got;
    rst_n = 1'b0;
    idle_inputs();
    exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 8'h00));
    #2;
    got = observed();
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected %h", got, e);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_forward();
    out_t e, got;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      WA3M = 3'd2; WA3W = 3'd2; RegWriteW = 1'b1;
      case (c)
        0: begin RA1E = 3'd2; RA2E = 3'd5; RegWriteM = 1'b1;
                 exp_q.push_back(mk(2'b10, 2'b00, 0, 0, 0, 0, 8'h00)); end
        1: begin RA1E = 3'd2; RA2E = 3'd5;
                 exp_q.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 8'h00)); end
        2: begin RA1E = 3'd5; RA2E = 3'd2;
                 exp_q.push_back(mk(2'b00, 2'b01, 0, 0, 0, 0, 8'h00)); end
        default: begin RA1E = 3'd3; RA2E = 3'd2; RegWriteW = 1'b0; RegWriteM = 1'b1;
                 exp_q.push_back(mk(2'b00, 2'b10, 0, 0, 0, 0, 8'h00)); end
      endcase
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL forward c%0d: got %h expected %h", c, got, e);
      end
    end
  endtask

  task automatic test_load_use();
    out_t e, got;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      MemtoRegE = 1'b1; WA3E = 3'd3;
      case (c)
        0: begin RA2D = 3'd3; UseBD = 1'b1; exp_q.push_back(mk(0, 0, 1, 1, 0, 1, 8'h00)); end
        1: begin RA2D = 3'd3; UseBD = 1'b0; exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00)); end
        2: begin RA1D = 3'd3; UseAD = 1'b1; exp_q.push_back(mk(0, 0, 1, 1, 0, 1, 8'h00)); end
        default: begin RA1D = 3'd3; UseAD = 1'b1; MemtoRegE = 1'b0;
                 exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00)); end
      endcase
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL load_use c%0d: got %h expected %h", c, got, e);
      end
    end
  endtask

  // Issue r4 latency 3, then read r4 from decode: stalls exactly three cycles.
  task automatic test_scoreboard();
    out_t e, got;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      if (c == 0) begin
        MCIssueE = 1'b1; WA3E = 3'd4; MCLatE = 4'd3;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00));
      end else begin
        RA1D = 3'd4; UseAD = 1'b1;
        if (c < 4) exp_q.push_back(mk(0, 0, 1, 1, 0, 1, 8'h10));
        else       exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00));
      end
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL scoreboard_raw c%0d: got %h expected %h", c, got, e);
      end
    end
  endtask

  // Zero latency ignored; WAW stall on r6; a reload of r7 overrides the long countdown.
  task automatic test_scoreboard_edges();
    out_t e, got;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      case (c)
        0: begin MCIssueE = 1; WA3E = 3'd1; MCLatE = 4'd0; exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00)); end
        1: begin MCIssueE = 1; WA3E = 3'd6; MCLatE = 4'd2; exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00)); end
        2: begin WriteD = 1; WA3D = 3'd6; exp_q.push_back(mk(0, 0, 1, 1, 0, 1, 8'h40)); end
        3: begin WriteD = 1; WA3D = 3'd6; MCIssueE = 1; WA3E = 3'd7; MCLatE = 4'd9;
                 exp_q.push_back(mk(0, 0, 1, 1, 0, 1, 8'h40)); end
        4: begin WriteD = 1; WA3D = 3'd6; MCIssueE = 1; WA3E = 3'd7; MCLatE = 4'd2;
                 exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h80)); end
        5: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h80));
        6: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h80));
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00));
      endcase
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL scoreboard_edges c%0d: got %h expected %h", c, got, e);
      end
    end
  endtask

  task automatic test_branch();
    out_t e, got;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      case (c)
        0: begin PCSrcD = 1; exp_q.push_back(mk(0, 0, 1, 0, 1, 0, 8'h00)); end
        1, 2: exp_q.push_back(mk(0, 0, 1, 0, 1, 0, 8'h00));
        3: exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00));
        4: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00));
        5: begin PCSrcD = 1; BranchTakenE = 1; exp_q.push_back(mk(0, 0, 1, 0, 1, 1, 8'h00)); end
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00));
      endcase
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL branch c%0d: got %h expected %h", c, got, e);
      end
    end
  endtask

  task automatic test_kill();
    out_t e, got;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      case (c)
        0: begin MCIssueE = 1; WA3E = 3'd7; MCLatE = 4'd9; exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00)); end
        1, 2: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h80));
        3: begin MCKill = 1; MCIssueE = 1; WA3E = 3'd2; MCLatE = 4'd5;
                 exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h80)); end
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00));
      endcase
      @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL kill c%0d: got %h expected %h", c, got, e);
      end
    end
  endtask

  // Reset asserted between edges mid-countdown must clear the busy vector at once.
  task automatic test_reset_mid();
    out_t e, got;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      case (c)
        0: begin MCIssueE = 1; WA3E = 3'd5; MCLatE = 4'd6; exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00)); end
        1: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h20));
        2: begin #1 rst_n = 1'b0; #1; exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00)); end
        3: begin exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00)); #1 rst_n = 1'b1; end
        default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00));
      endcase
      if (c == 2) #1;
      else @(negedge clk);
      got = observed();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset_mid c%0d: got %h expected %h", c, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_scoreboard();
    test_scoreboard_edges();
    test_branch();
    test_kill();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 SHALL have parameter AW, default 3: register address width; NREG = 2**AW registers.
REQ-002 SHALL have parameter LW, default 4: multi-cycle latency counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports RA1D, RA2D, WA3D  in  AW  source/destination addresses, Decode.
REQ-006 SHALL have ports UseAD, UseBD, WriteD  in  1  operand-A/operand-B/destination valid, Decode.
REQ-007 SHALL have ports RA1E, RA2E, WA3E  in  AW  addresses, Execute.
REQ-008 SHALL have ports WA3M, WA3W  in  AW  destination addresses, Memory/Writeback.
REQ-009 SHALL have ports RegWriteM, RegWriteW, MemtoRegE  in  1  write enables; load in Execute.
REQ-010 SHALL have ports PCSrcD, BranchTakenE  in  1  PC-writing instruction in Decode; branch resolved taken in Execute.
REQ-011 SHALL have ports MCIssueE  in  1, MCLatE  in  LW, MCKill  in  1: multi-cycle op issue, its writeback latency, clear all.
REQ-012 SHALL have ports ForwardAE, ForwardBE  out  2  00 regfile, 01 Writeback, 10 Memory.
REQ-013 SHALL have ports StallF, StallD, FlushD, FlushE  out  1  pipeline control.
REQ-014 SHALL have port SBBusy  out  NREG  per-register scoreboard busy vector.

Function
REQ-015 SHALL set ForwardAE = 10 when RA1E==WA3M and RegWriteM, else 01 when RA1E==WA3W and RegWriteW, else 00; ForwardBE identical using RA2E; Memory wins ties.
REQ-016 SHALL compute LDRstall = MemtoRegE and ((UseAD and RA1D==WA3E) or (UseBD and RA2D==WA3E)).
REQ-017 SHALL hold one LW-bit counter cnt[r] per register; SBBusy[r] = (cnt[r] != 0).
REQ-018 SHALL load cnt[MCLatE-addressed WA3E] <= MCLatE when MCIssueE and MCLatE != 0; MCLatE == 0 is ignored (no state change).
REQ-019 SHALL decrement every nonzero cnt[r] by 1 per cycle, except a register loaded that cycle takes the load value (load wins over decrement).
REQ-020 SHALL compute SBstall = (UseAD and SBBusy[RA1D]) or (UseBD and SBBusy[RA2D]) or (WriteD and SBBusy[WA3D]) (RAW and WAW).
REQ-021 SHALL clear all cnt synchronously when MCKill, overriding a same-cycle MCIssueE.
REQ-022 SHALL hold a 3-bit PC-write pending shift register pend[2:0] (E, M, W): pend[0] <= PCSrcD and not StallD and not BranchTakenE; pend[1] <= pend[0]; pend[2] <= pend[1].
REQ-023 SHALL drive StallD = LDRstall or SBstall.
REQ-024 SHALL drive StallF = StallD or PCSrcD or pend[0] or pend[1].
REQ-025 SHALL drive FlushE = StallD or BranchTakenE.
REQ-026 SHALL drive FlushD = PCSrcD or pend[0] or pend[1] or pend[2] or BranchTakenE.
REQ-027 SHALL produce all outputs combinationally from current inputs and state (zero-cycle latency); state updates take effect next cycle.

Reset
REQ-028 SHALL clear all cnt and pend to 0 immediately on rst_n low, independent of clk.
REQ-029 SHALL, with rst_n low and all inputs 0, drive every output to 0; SBBusy SHALL read 0 throughout reset.
REQ-030 SHALL resume normal operation on the first rising clk after rst_n deasserts; reset mid-countdown discards all in-flight entries.

Verification
REQ-031 SHALL cover: RA1E=2, WA3M=2, RegWriteM=1, WA3W=2, RegWriteW=1 -> ForwardAE=10; drop RegWriteM -> 01; RA2E=5 unmatched -> ForwardBE=00.
REQ-032 SHALL cover: MemtoRegE=1, WA3E=3, RA2D=3, UseBD=1 -> StallD=StallF=FlushE=1 for that cycle; UseBD=0 -> all 0.
REQ-033 SHALL cover: MCIssueE, WA3E=4, MCLatE=3 -> SBBusy[4]=1 for exactly 3 cycles; RA1D=4, UseAD=1 stalls those 3 cycles, released on 4th.
REQ-034 SHALL cover: PCSrcD pulse 1 cycle, no stalls -> StallF high 3 cycles (D, E, M), FlushD high 4 cycles (D, E, M, W).
REQ-035 SHALL cover: PCSrcD with BranchTakenE same cycle -> pend stays 0; MCKill during MCLatE=9 countdown -> SBBusy all 0 next cycle; rst_n low mid-countdown -> SBBusy 0 immediately.
